alu_req_arbiter: RTL and testbench

- Shares the single registered 4-bit ALU (op codes ADD/SUB/MUL/DIV, one-cycle registered result) among NUM_REQ requesters.
- Uses round-robin arbitration. Each requester gets a valid/ready request channel and a valid/ready response channel.
- Sequences each transaction through the ALU's one-cycle result latency.
- Intercepts divide-by-zero, returns an error flag and does not use the ALU result for that transaction.

---
 rtl/alu_req_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_req_arbiter.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Round-robin controller that shares one registered 4-bit ALU among NUM_REQ requesters.
// Divide-by-zero requests never reach the ALU result path: they answer 4'hF with rsp_err set.
module alu_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [2*NUM_REQ-1:0] req_op,
    input  logic [4*NUM_REQ-1:0] req_rs,
    input  logic [4*NUM_REQ-1:0] req_rt,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [3:0]           rsp_data,
    output logic                 rsp_err,
    output logic [1:0]           alu_op,
    output logic [3:0]           alu_rs,
    output logic [3:0]           alu_rt,
    input  logic [3:0]           alu_result,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int               PTR_W1    = PTR_W + 1;
    localparam logic [PTR_W:0]   NUM_REQ_W = PTR_W1'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NUM_REQ - 1);

    state_t           state;
    state_t           state_nxt;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] winner;
    logic [PTR_W:0]   scan_idx;
    logic             found;
    logic             accept;
    logic [1:0]       win_op;
    logic [3:0]       win_rs;
    logic [3:0]       win_rt;
    logic             win_div0;

    // Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ; first valid one wins.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + PTR_W1'(k);
            if (scan_idx >= NUM_REQ_W) scan_idx = scan_idx - NUM_REQ_W;
            if (!found && req_valid[scan_idx[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = scan_idx[PTR_W-1:0];
            end
        end
    end

    // Only the winner's fields are selected, so junk on other requesters cannot leak out.
    assign win_op   = req_op[{winner, 1'b0} +: 2];
    assign win_rs   = req_rs[{winner, 2'b00} +: 4];
    assign win_rt   = req_rt[{winner, 2'b00} +: 4];
    assign win_div0 = (win_op == 2'b11) && (win_rt == 4'd0);

    // Handshakes: a transfer happens on a clk edge where valid and ready are both 1.
    // req_ready is asserted only in IDLE, only for the winner, and only outside reset;
    // rsp_valid is asserted only in RESP for the owner, and only rsp_ready[owner] is honoured.
    assign accept = (state == IDLE) && found && reset;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_ready[winner] = 1'b1;
                    state_nxt         = win_div0 ? RESP : EXEC;
                end
            end
            EXEC: state_nxt = WAIT;
            WAIT: state_nxt = RESP;
            RESP: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr   <= '0;
            owner    <= '0;
            alu_op   <= '0;
            alu_rs   <= '0;
            alu_rt   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                owner  <= winner;
                rr_ptr <= (winner == LAST_REQ) ? '0 : winner + 1'b1;
                alu_op <= win_op;
                alu_rs <= win_rs;
                alu_rt <= win_rt;
                if (win_div0) begin
                    rsp_data <= 4'hF;
                    rsp_err  <= 1'b1;
                end
            end
            // The ALU result registered at the end of EXEC is visible during WAIT.
            if (state == WAIT) begin
                rsp_data <= alu_result;
                rsp_err  <= 1'b0;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a registered ALU model plus a spec-level reference
// model (round-robin winner, modulo-16 arithmetic, expected-response queue).
`timescale 1ns/1ps
module tb_alu_req_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [2*N-1:0] req_op;
    logic [4*N-1:0] req_rs;
    logic [4*N-1:0] req_rt;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [3:0]     rsp_data;
    logic           rsp_err;
    logic [1:0]     alu_op;
    logic [3:0]     alu_rs;
    logic [3:0]     alu_rt;
    logic [3:0]     alu_result = 4'h0;
    logic           busy;
    logic [1:0]     dbg_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mp       = 0;
    int f_op[N];
    int f_a[N];
    int f_b[N];
    logic [4:0] exp_q[$];

    alu_req_arbiter #(.NUM_REQ(N), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_op(alu_op), .alu_rs(alu_rs), .alu_rt(alu_rt),
        .alu_result(alu_result), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / environment ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered ALU: operands sampled on each edge, result visible the following cycle.
    always @(posedge clk) begin
        case (alu_op)
            2'b00:   alu_result <= alu_rs + alu_rt;
            2'b01:   alu_result <= alu_rs - alu_rt;
            2'b10:   alu_result <= alu_rs * alu_rt;
            default: alu_result <= (alu_rt == 4'd0) ? 4'h0 : alu_rs / alu_rt;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [4:0] model_rsp(input int op, input int a, input int b);
        case (op)
            0:       return {1'b0, 4'((a + b) % 16)};
            1:       return {1'b0, 4'((a - b + 16) % 16)};
            2:       return {1'b0, 4'((a * b) % 16)};
            default: return (b == 0) ? 5'h1F : {1'b0, 4'(a / b)};
        endcase
    endfunction

    function automatic int model_winner(input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(mp + k) % N] === 1'b1) return (mp + k) % N;
        return -1;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i] === 1'b1) return i;
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int op, input int a, input int b);
        req_op[2*i +: 2] = 2'(op);
        req_rs[4*i +: 4] = 4'(a);
        req_rt[4*i +: 4] = 4'(b);
        req_valid[i]     = 1'b1;
        f_op[i] = op;
        f_a[i]  = a;
        f_b[i]  = b;
    endtask

    task automatic wait_ready(output int who, output int at, output bit to);
        to = 1'b1; who = -1; at = 0;
        #1;
        for (int n = 0; n < 64; n++) begin
            if (req_ready !== '0) begin
                who = idx_of(req_ready); at = cyc; to = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_rsp(output int who, output int at, output bit to);
        to = 1'b1; who = -1; at = 0;
        #1;
        for (int n = 0; n < 64; n++) begin
            if (rsp_valid !== '0) begin
                who = idx_of(rsp_valid); at = cyc; to = 1'b0;
                break;
            end
            tick();
        end
    endtask

    // One complete transaction on requester i with rsp_ready[i] held high.
    task automatic do_txn(input int i, input int op, input int a, input int b,
                          output int who, output int lat, output logic [4:0] got, output bit to);
        int g, r, rw;
        bit t1, t2;
        set_req(i, op, a, b);
        wait_ready(who, g, t1);
        tick();
        req_valid[i] = 1'b0;
        wait_rsp(rw, r, t2);
        lat = r - g;
        got = {rsp_err, rsp_data};
        to  = t1 | t2 | (rw != i);
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; req_valid = '0; rsp_ready = '1;
        req_op = '0; req_rs = '0; req_rt = '0;
        repeat (3) tick();
        mp = 0;
        checks++;
        if ({req_ready, rsp_valid, busy, dbg_state, alu_op, alu_rs, alu_rt, rsp_data, rsp_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got rr=%b rv=%b busy=%b st=%0d op=%0d rs=%0d rt=%0d d=%0d e=%b want all 0",
                     req_ready, rsp_valid, busy, dbg_state, alu_op, alu_rs, alu_rt, rsp_data, rsp_err);
        end
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== '0) begin
            failures++;
            $display("FAIL reset_no_grant: got req_ready=%b want 0000", req_ready);
        end
        req_valid = '0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_add();
        int who, g, r, rw, w;
        bit to;
        set_req(0, 0, 9, 8);
        w = model_winner(4'b0001);
        wait_ready(who, g, to);
        checks++;
        if (to || req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL add_grant: got req_ready=%b who=%0d want 0001 who=%0d", req_ready, who, w);
        end
        mp = (w + 1) % N;
        tick();
        req_valid[0] = 1'b0;
        checks++;
        if (busy !== 1'b1 || dbg_state !== 2'd1 || req_ready !== '0) begin
            failures++;
            $display("FAIL add_exec: got busy=%b st=%0d rr=%b want busy=1 st=1 rr=0000", busy, dbg_state, req_ready);
        end
        wait_rsp(rw, r, to);
        checks++;
        if (to || r - g !== 3 || rsp_valid !== 4'b0001) begin
            failures++;
            $display("FAIL add_latency: got lat=%0d rv=%b want lat=3 rv=0001", r - g, rsp_valid);
        end
        checks++;
        if ({rsp_err, rsp_data} !== model_rsp(0, 9, 8) || busy !== 1'b1) begin
            failures++;
            $display("FAIL add_data: got err=%b data=%0d busy=%b want err=0 data=1 busy=1", rsp_err, rsp_data, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || rsp_valid !== '0) begin
            failures++;
            $display("FAIL add_done: got busy=%b rv=%b want busy=0 rv=0000", busy, rsp_valid);
        end
    endtask

    task automatic test_arith_sweep();
        int ops[4] = '{1, 2, 3, 3};
        int as[4]  = '{3, 5, 13, 7};
        int bs[4]  = '{5, 7, 4, 0};
        int who, lat, w, want_lat;
        logic [4:0] got, want;
        bit to;
        for (int k = 0; k < 4; k++) begin
            w = model_winner(4'b0010);
            want = model_rsp(ops[k], as[k], bs[k]);
            want_lat = (ops[k] == 3 && bs[k] == 0) ? 1 : 3;
            do_txn(1, ops[k], as[k], bs[k], who, lat, got, to);
            mp = (w + 1) % N;
            checks++;
            if (to || who !== w || lat !== want_lat) begin
                failures++;
                $display("FAIL sweep_timing[%0d]: got who=%0d lat=%0d want who=%0d lat=%0d", k, who, lat, w, want_lat);
            end
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL sweep_data[%0d]: got err=%b data=%0d want err=%b data=%0d", k, got[4], got[3:0], want[4], want[3:0]);
            end
        end
    endtask

    task automatic test_round_robin();
        int who, g, prev, r, rw, w;
        bit to;
        logic [4:0] want;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        mp = 0;
        for (int i = 0; i < N; i++)
            set_req(i, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(1, 15));
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            wait_ready(who, g, to);
            w = model_winner(4'b1111);
            checks++;
            if (to || who !== w || w !== k % N) begin
                failures++;
                $display("FAIL rr_grant[%0d]: got %0d want %0d", k, who, k % N);
            end
            if (k > 0) begin
                checks++;
                if (g - prev !== 4) begin
                    failures++;
                    $display("FAIL rr_spacing[%0d]: got %0d cycles want 4", k, g - prev);
                end
            end
            prev = g;
            mp = (w + 1) % N;
            exp_q.push_back(model_rsp(f_op[w], f_a[w], f_b[w]));
            tick();
            set_req(w, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(1, 15));
            wait_rsp(rw, r, to);
            want = exp_q.pop_front();
            checks++;
            if (to || rw !== w || {rsp_err, rsp_data} !== want) begin
                failures++;
                $display("FAIL rr_rsp[%0d]: got owner=%0d e=%b d=%0d want owner=%0d e=%b d=%0d",
                         k, rw, rsp_err, rsp_data, w, want[4], want[3:0]);
            end
            tick();
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_back_pressure();
        int who, g, r, rw, w;
        bit to;
        logic [4:0] want;
        rsp_ready = 4'b1011;
        set_req(2, 2, 6, 3);
        w = model_winner(4'b0100);
        wait_ready(who, g, to);
        checks++;
        if (to || who !== w) begin
            failures++;
            $display("FAIL bp_grant2: got %0d want %0d", who, w);
        end
        mp = (w + 1) % N;
        tick();
        req_valid[2] = 1'b0;
        set_req(0, 0, 1, 2);
        set_req(3, 1, 2, 7);
        want = model_rsp(2, 6, 3);
        wait_rsp(rw, r, to);
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++;
            if (to || rsp_valid !== 4'b0100 || {rsp_err, rsp_data} !== want || req_ready !== '0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got rv=%b e=%b d=%0d rr=%b want rv=0100 e=%b d=%0d rr=0000",
                         n, rsp_valid, rsp_err, rsp_data, req_ready, want[4], want[3:0]);
            end
        end
        rsp_ready = '1;
        tick();
        for (int j = 0; j < 2; j++) begin
            w = model_winner(req_valid);
            wait_ready(who, g, to);
            checks++;
            if (to || who !== w || w !== 3 - 3 * j) begin
                failures++;
                $display("FAIL bp_next_grant[%0d]: got %0d want %0d", j, who, 3 - 3 * j);
            end
            mp = (w + 1) % N;
            want = model_rsp(f_op[w], f_a[w], f_b[w]);
            tick();
            req_valid[w] = 1'b0;
            wait_rsp(rw, r, to);
            checks++;
            if (to || rw !== w || {rsp_err, rsp_data} !== want) begin
                failures++;
                $display("FAIL bp_rsp[%0d]: got owner=%0d d=%0d want owner=%0d d=%0d", j, rw, rsp_data, w, want[3:0]);
            end
            tick();
        end
    endtask

    task automatic test_wrong_ready();
        int who, g, r, rw, w;
        bit to;
        logic [4:0] want;
        rsp_ready = 4'b0001;
        set_req(1, 0, 15, 15);
        w = model_winner(4'b0010);
        want = model_rsp(0, 15, 15);
        wait_ready(who, g, to);
        mp = (w + 1) % N;
        tick();
        req_valid[1] = 1'b0;
        wait_rsp(rw, r, to);
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (to || rsp_valid !== 4'b0010 || dbg_state !== 2'd3 || {rsp_err, rsp_data} !== want) begin
                failures++;
                $display("FAIL wrong_ready_hold[%0d]: got rv=%b st=%0d d=%0d want rv=0010 st=3 d=%0d",
                         n, rsp_valid, dbg_state, rsp_data, want[3:0]);
            end
        end
        rsp_ready = 4'b0010;
        tick();
        checks++;
        if (rsp_valid !== '0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL wrong_ready_release: got rv=%b st=%0d want rv=0000 st=0", rsp_valid, dbg_state);
        end
        rsp_ready = '1;
    endtask

    task automatic test_reset_mid_op();
        int who, g, r, rw, w;
        bit to;
        logic [4:0] want;
        set_req(1, 2, 5, 3);
        w = model_winner(4'b0010);
        wait_ready(who, g, to);
        mp = (w + 1) % N;
        tick();
        checks++;
        if (to || dbg_state !== 2'd1) begin
            failures++;
            $display("FAIL midop_exec: got st=%0d want 1", dbg_state);
        end
        reset = 1'b0;
        set_req(3, 0, 4, 4);
        tick();
        mp = 0;
        checks++;
        if ({req_ready, rsp_valid, busy, dbg_state, alu_op, alu_rs, alu_rt, rsp_data, rsp_err} !== '0) begin
            failures++;
            $display("FAIL midop_reset: got rr=%b rv=%b busy=%b st=%0d op=%0d rs=%0d rt=%0d d=%0d want all 0",
                     req_ready, rsp_valid, busy, dbg_state, alu_op, alu_rs, alu_rt, rsp_data);
        end
        reset = 1'b1;
        for (int j = 0; j < 2; j++) begin
            w = model_winner(req_valid);
            wait_ready(who, g, to);
            checks++;
            if (to || who !== w || w !== 1 + 2 * j) begin
                failures++;
                $display("FAIL midop_regrant[%0d]: got %0d want %0d", j, who, 1 + 2 * j);
            end
            mp = (w + 1) % N;
            want = model_rsp(f_op[w], f_a[w], f_b[w]);
            tick();
            req_valid[w] = 1'b0;
            wait_rsp(rw, r, to);
            checks++;
            if (to || rw !== w || {rsp_err, rsp_data} !== want) begin
                failures++;
                $display("FAIL midop_rsp[%0d]: got owner=%0d d=%0d want owner=%0d d=%0d", j, rw, rsp_data, w, want[3:0]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int who, g, r, rw, w, stall, want_lat;
        bit to;
        logic [N-1:0] mask;
        logic [4:0] want;
        for (int it = 0; it < 30; it++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    set_req(i, $urandom_range(0, 3), $urandom_range(0, 15),
                            ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15));
                end else begin
                    req_op[2*i +: 2] = 'x;
                    req_rs[4*i +: 4] = 'x;
                    req_rt[4*i +: 4] = 'x;
                    req_valid[i]     = 1'b0;
                end
            end
            w = model_winner(mask);
            wait_ready(who, g, to);
            checks++;
            if (to || who !== w) begin
                failures++;
                $display("FAIL rand_grant[%0d]: got %0d want %0d (mask %b)", it, who, w, mask);
            end
            if (w < 0) w = 0;
            mp = (w + 1) % N;
            exp_q.push_back(model_rsp(f_op[w], f_a[w], f_b[w]));
            want_lat = (f_op[w] == 3 && f_b[w] == 0) ? 1 : 3;
            stall = $urandom_range(0, 3);
            rsp_ready = '1;
            if (stall > 0) rsp_ready[w] = 1'b0;
            tick();
            req_valid = '0;
            wait_rsp(rw, r, to);
            checks++;
            if (to || r - g !== want_lat) begin
                failures++;
                $display("FAIL rand_latency[%0d]: got %0d want %0d", it, r - g, want_lat);
            end
            repeat (stall) tick();
            want = exp_q.pop_front();
            checks++;
            if (rsp_valid !== N'(1 << w) || {rsp_err, rsp_data} !== want) begin
                failures++;
                $display("FAIL rand_rsp[%0d]: got rv=%b e=%b d=%h want owner=%0d e=%b d=%h",
                         it, rsp_valid, rsp_err, rsp_data, w, want[4], want[3:0]);
            end
            rsp_ready = '1;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_arith_sweep();
        test_round_robin();
        test_back_pressure();
        test_wrong_ready();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
